avalon_pipe_bridge: RTL and testbench



---
 rtl/avalon_pipe_bridge.sv | 128 ++++++++++++
 tb/tb_avalon_pipe_bridge.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pipe_bridge.sv
// Pipelined Avalon-MM bridge: upstream slave commands are queued in a small FIFO and
// replayed in order on the downstream master port, with a cap on outstanding reads.
module avalon_pipe_bridge #(
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int MAX_PENDING = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_read,
  input  logic                            in_write,
  input  logic [ADDR_W-1:0]               in_address,
  input  logic [DATA_W-1:0]               in_writedata,
  input  logic [DATA_W/8-1:0]             in_byteenable,
  output logic                            in_waitrequest,
  output logic [DATA_W-1:0]               in_readdata,
  output logic                            in_readdatavalid,
  output logic                            out_read,
  output logic                            out_write,
  output logic [ADDR_W-1:0]               out_address,
  output logic [DATA_W-1:0]               out_writedata,
  output logic [DATA_W/8-1:0]             out_byteenable,
  input  logic                            out_waitrequest,
  input  logic [DATA_W-1:0]               out_readdata,
  input  logic                            out_readdatavalid,
  output logic [$clog2(CMD_DEPTH):0]      cmd_level,
  output logic [$clog2(MAX_PENDING):0]    pending_reads
);

  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(CMD_DEPTH);
  localparam int LW   = PW + 1;
  localparam int RW   = $clog2(MAX_PENDING) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(CMD_DEPTH);
  localparam logic [RW-1:0] PEND_MAX = RW'(MAX_PENDING);

  // Handshake: a command transfers on a side in any cycle where its request (read or
  // write) is high and that side's waitrequest is low; otherwise the request and its
  // address/data/byteenable stay stable. Read responses carry no handshake.

  logic              mem_wr   [CMD_DEPTH];
  logic [ADDR_W-1:0] mem_addr [CMD_DEPTH];
  logic [DATA_W-1:0] mem_data [CMD_DEPTH];
  logic [BE_W-1:0]   mem_be   [CMD_DEPTH];

  logic [LW-1:0]     wr_ptr;
  logic [LW-1:0]     rd_ptr;
  logic [LW-1:0]     level;
  logic [RW-1:0]     pend_cnt;
  logic              rdv_q;
  logic [DATA_W-1:0] rdata_q;

  logic              empty;
  logic              full;
  logic              head_valid;
  logic              head_is_wr;
  logic [PW-1:0]     head_idx;
  logic              push;
  logic              pop;
  logic              read_pop;

  assign level      = wr_ptr - rd_ptr;
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (level == FULL_LVL);
  assign head_idx   = rd_ptr[PW-1:0];
  assign head_valid = rst_n && !empty;
  assign head_is_wr = mem_wr[head_idx];

  assign in_waitrequest = !rst_n || full;
  assign push           = (in_read || in_write) && !in_waitrequest;

  // A read head waits here when the outstanding-read budget is spent; nothing bypasses it.
  assign out_write      = head_valid && head_is_wr;
  assign out_read       = head_valid && !head_is_wr && (pend_cnt < PEND_MAX);
  assign out_address    = head_valid ? mem_addr[head_idx] : '0;
  assign out_writedata  = head_valid ? mem_data[head_idx] : '0;
  assign out_byteenable = head_valid ? mem_be[head_idx]   : '0;

  assign pop      = (out_read || out_write) && !out_waitrequest;
  assign read_pop = out_read && !out_waitrequest;

  assign cmd_level        = rst_n ? level : '0;
  assign pending_reads    = rst_n ? pend_cnt : '0;
  assign in_readdatavalid = rst_n && rdv_q;
  assign in_readdata      = rst_n ? rdata_q : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wr[wr_ptr[PW-1:0]]   <= in_write;
      mem_addr[wr_ptr[PW-1:0]] <= in_address;
      mem_data[wr_ptr[PW-1:0]] <= in_writedata;
      mem_be[wr_ptr[PW-1:0]]   <= in_byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
    end
  end

  // A response arriving with the issuing pop cancels out; a stray one at zero is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_cnt <= '0;
    end else if (read_pop && !out_readdatavalid) begin
      pend_cnt <= pend_cnt + RW'(1);
    end else if (!read_pop && out_readdatavalid && (pend_cnt != '0)) begin
      pend_cnt <= pend_cnt - RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdv_q <= out_readdatavalid;
      if (out_readdatavalid) rdata_q <= out_readdata;
    end
  end

endmodule

// File: tb/tb_avalon_pipe_bridge.sv
// Bench for avalon_pipe_bridge: directed scenarios with literal checks plus random
// traffic, all compared every cycle against a queue-level model of the bridge.
module tb_avalon_pipe_bridge;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int MAXP   = 2;
  localparam int CW     = 1 + ADDR_W + DATA_W + DATA_W/8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_read = 1'b0;
  logic              in_write = 1'b0;
  logic [ADDR_W-1:0] in_address = '0;
  logic [DATA_W-1:0] in_writedata = '0;
  logic [3:0]        in_byteenable = '0;
  logic              in_waitrequest;
  logic [DATA_W-1:0] in_readdata;
  logic              in_readdatavalid;
  logic              out_read;
  logic              out_write;
  logic [ADDR_W-1:0] out_address;
  logic [DATA_W-1:0] out_writedata;
  logic [3:0]        out_byteenable;
  logic              out_waitrequest = 1'b0;
  logic [DATA_W-1:0] out_readdata = '0;
  logic              out_readdatavalid = 1'b0;
  logic [2:0]        cmd_level;
  logic [1:0]        pending_reads;

  avalon_pipe_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(DEPTH), .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_read(in_read), .in_write(in_write), .in_address(in_address),
    .in_writedata(in_writedata), .in_byteenable(in_byteenable),
    .in_waitrequest(in_waitrequest), .in_readdata(in_readdata),
    .in_readdatavalid(in_readdatavalid),
    .out_read(out_read), .out_write(out_write), .out_address(out_address),
    .out_writedata(out_writedata), .out_byteenable(out_byteenable),
    .out_waitrequest(out_waitrequest), .out_readdata(out_readdata),
    .out_readdatavalid(out_readdatavalid),
    .cmd_level(cmd_level), .pending_reads(pending_reads)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [CW-1:0]     exp_q[$];
  int                m_pend = 0;
  logic              m_rdv = 1'b0;
  logic [DATA_W-1:0] m_rdata = '0;
  bit                started = 1'b0;
  int                checks = 0;
  int                failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an in-order command queue, an outstanding-read count, and a one-cycle
  // delayed copy of the downstream response.
  always @(posedge clk) begin
    logic [CW-1:0] h;
    bit acc, pop, rpop;
    started = 1'b1;
    if (!rst_n) begin
      exp_q.delete();
      m_pend  = 0;
      m_rdv   = 1'b0;
      m_rdata = '0;
    end else begin
      acc  = (in_read || in_write) && (exp_q.size() < DEPTH);
      pop  = 1'b0;
      rpop = 1'b0;
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        if (h[CW-1]) pop = !out_waitrequest;
        else if (m_pend < MAXP) begin
          pop  = !out_waitrequest;
          rpop = pop;
        end
      end
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({in_write, in_address, in_writedata, in_byteenable});
      if (rpop && !out_readdatavalid) m_pend = m_pend + 1;
      else if (!rpop && out_readdatavalid && m_pend > 0) m_pend = m_pend - 1;
      m_rdv = out_readdatavalid;
      if (out_readdatavalid) m_rdata = out_readdata;
    end
  end

  // Compare process: every negedge once the model has seen a clock edge.
  always @(negedge clk) begin
    logic [CW-1:0] h;
    bit has;
    if (started) begin
      has = rst_n && (exp_q.size() > 0);
      h   = has ? exp_q[0] : '0;
      chk("cmp_waitrequest", 64'(in_waitrequest), 64'(!rst_n || exp_q.size() == DEPTH));
      chk("cmp_out_write", 64'(out_write), 64'(has && h[CW-1]));
      chk("cmp_out_read", 64'(out_read), 64'(has && !h[CW-1] && m_pend < MAXP));
      chk("cmp_cmd_level", 64'(cmd_level), 64'(exp_q.size()));
      chk("cmp_pending", 64'(pending_reads), 64'(m_pend));
      chk("cmp_rdvalid", 64'(in_readdatavalid), 64'(m_rdv));
      chk("cmp_rdata", 64'(in_readdata), 64'(m_rdata));
      if (has) begin
        chk("cmp_address", 64'(out_address), 64'(h[CW-2 -: ADDR_W]));
        chk("cmp_byteenable", 64'(out_byteenable), 64'(h[3:0]));
        if (h[CW-1]) chk("cmp_writedata", 64'(out_writedata), 64'(h[35:4]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [3:0] be);
    in_read = rd; in_write = wr; in_address = a; in_writedata = d; in_byteenable = be;
  endtask

  task automatic idle_cmd();
    drive_cmd(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic respond(input logic v, input logic [DATA_W-1:0] d);
    out_readdatavalid = v; out_readdata = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with a write held on the upstream side.
    drive_cmd(1'b0, 1'b1, 3'h0, 32'h1, 4'hF);
    step(); step();
    chk("reset_waitrequest", 64'(in_waitrequest), 64'd1);
    chk("reset_out_rw", 64'({out_read, out_write}), 64'd0);
    chk("reset_cmd_level", 64'(cmd_level), 64'd0);
    chk("reset_pending", 64'(pending_reads), 64'd0);
    idle_cmd();
    rst_n = 1'b1;
    step();

    // Single write, one-cycle command latency, one-cycle transfer.
    drive_cmd(1'b0, 1'b1, 3'h5, 32'hDEADBEEF, 4'hF);
    step();
    idle_cmd();
    chk("single_out_write", 64'(out_write), 64'd1);
    chk("single_addr", 64'(out_address), 64'h5);
    chk("single_data", 64'(out_writedata), 64'hDEADBEEF);
    chk("single_be", 64'(out_byteenable), 64'hF);
    step();
    chk("single_done", 64'(out_write), 64'd0);

    // Back-pressure fill, then release.
    out_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b0, 1'b1, 3'(i), 32'hA0 + 32'(i), 4'hF);
      step();
    end
    drive_cmd(1'b0, 1'b1, 3'h4, 32'hA4, 4'hF);
    step();
    chk("fill_level", 64'(cmd_level), 64'd4);
    chk("fill_waitrequest", 64'(in_waitrequest), 64'd1);
    chk("fill_head_held", 64'(out_address), 64'h0);
    out_waitrequest = 1'b0;
    step();
    chk("drain_head1", 64'(out_address), 64'h1);
    chk("drain_level1", 64'(cmd_level), 64'd3);
    step();
    idle_cmd();
    chk("drain_head2", 64'(out_address), 64'h2);
    chk("drain_level2", 64'(cmd_level), 64'd3);
    repeat (5) step();
    chk("drain_empty", 64'(cmd_level), 64'd0);

    // Outstanding-read limit.
    for (int i = 1; i <= 3; i++) begin
      drive_cmd(1'b1, 1'b0, 3'(i), 32'h0, 4'hF);
      step();
    end
    idle_cmd();
    step(); step();
    chk("limit_pending", 64'(pending_reads), 64'd2);
    chk("limit_out_read", 64'(out_read), 64'd0);
    chk("limit_level", 64'(cmd_level), 64'd1);
    chk("limit_held_addr", 64'(out_address), 64'h3);
    respond(1'b1, 32'h12345678);
    step();
    respond(1'b0, 32'h0);
    chk("limit_rdvalid", 64'(in_readdatavalid), 64'd1);
    chk("limit_rdata", 64'(in_readdata), 64'h12345678);
    chk("limit_third_issues", 64'(out_read), 64'd1);
    step();
    chk("limit_pending_again", 64'(pending_reads), 64'd2);
    chk("limit_rdata_hold", 64'(in_readdata), 64'h12345678);
    respond(1'b1, 32'h11);
    step(); step();
    respond(1'b0, 32'h0);
    step();
    chk("limit_pending_zero", 64'(pending_reads), 64'd0);

    // Pop and response in the same cycle, then a stray response.
    drive_cmd(1'b1, 1'b0, 3'h6, 32'h0, 4'h1);
    step();
    drive_cmd(1'b1, 1'b0, 3'h7, 32'h0, 4'h2);
    step();
    idle_cmd();
    chk("same_pending_pre", 64'(pending_reads), 64'd1);
    chk("same_out_read", 64'(out_read), 64'd1);
    respond(1'b1, 32'h0BADF00D);
    step();
    chk("same_pending_kept", 64'(pending_reads), 64'd1);
    step();
    respond(1'b0, 32'h0);
    step();
    chk("same_pending_zero", 64'(pending_reads), 64'd0);
    respond(1'b1, 32'hCAFEF00D);
    step();
    respond(1'b0, 32'h0);
    chk("stray_pending", 64'(pending_reads), 64'd0);
    chk("stray_rdvalid", 64'(in_readdatavalid), 64'd1);
    chk("stray_rdata", 64'(in_readdata), 64'hCAFEF00D);
    step();

    // Read and write together: write wins.
    drive_cmd(1'b1, 1'b1, 3'h2, 32'h55, 4'h3);
    step();
    idle_cmd();
    chk("rw_out_write", 64'(out_write), 64'd1);
    chk("rw_out_read", 64'(out_read), 64'd0);
    chk("rw_addr", 64'(out_address), 64'h2);
    step();
    chk("rw_single", 64'(out_write), 64'd0);

    // Reset with three queued entries.
    out_waitrequest = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_cmd(1'b0, 1'b1, 3'(i), 32'hB0 + 32'(i), 4'hF);
      step();
    end
    idle_cmd();
    chk("mid_level", 64'(cmd_level), 64'd3);
    rst_n = 1'b0;
    step();
    chk("mid_reset_level", 64'(cmd_level), 64'd0);
    chk("mid_reset_wait", 64'(in_waitrequest), 64'd1);
    rst_n = 1'b1;
    out_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_quiet", 64'({out_read, out_write}), 64'd0);
    end

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      drive_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 3'($urandom),
                $urandom, 4'($urandom));
      out_waitrequest = ($urandom_range(0, 2) == 0);
      respond($urandom_range(0, 3) == 0, $urandom);
      if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      step();
    end
    rst_n = 1'b1;
    idle_cmd();
    out_waitrequest = 1'b0;
    respond(1'b0, 32'h0);
    repeat (10) step();
    respond(1'b1, 32'h77);
    repeat (4) step();
    respond(1'b0, 32'h0);
    step();
    chk("final_level", 64'(cmd_level), 64'd0);
    chk("final_pending", 64'(pending_reads), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
